// File: rtl/memory_request_arbiter.sv
// Two-requester (cpu / program loader) front end for the single memory controller port.
// Define ARB_TIMEOUT_EN to add a WAIT watchdog that ends a stalled transaction with err and 16'hDEAD.
module memory_request_arbiter #(
    parameter int PRIO_MODE      = 0,
    parameter int REQ_HOLD       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic [15:0] ldr_rdata,
    output logic        ldr_done,
    output logic        ldr_err,
    output logic        mc_request,
    output logic        mc_request_type,
    output logic [15:0] mc_request_address,
    output logic [15:0] mc_memory_write,
    input  logic [15:0] mc_data_out,
    input  logic        mc_memory_ready,
    input  logic        mc_write_complete
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, next_state;
    logic       rr_ptr;
    logic       owner;
    logic [2:0] hold_cnt;
    logic       grant_valid;
    logic       grant_sel;
    logic       hold_last;
    logic       complete;
    logic       finish;
    logic       timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = ISSUE;
            ISSUE:   if (hold_last)   next_state = WAIT;
            WAIT:    if (finish)      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // grant_sel: 0 = cpu, 1 = ldr; only the pulse type matching the latched command completes it
    always_comb begin
        grant_valid = cpu_req | ldr_req;
        grant_sel   = ldr_req;
        if (cpu_req && ldr_req)
            grant_sel = (PRIO_MODE == 1) ? 1'b1 : rr_ptr;
        hold_last = (state == ISSUE) && (hold_cnt == 3'(REQ_HOLD));
        complete  = (state == WAIT) &&
                    (mc_request_type ? mc_write_complete : mc_memory_ready);
        finish    = complete | timed_out;
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign timed_out = (state == WAIT) && !complete &&
                       (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= 8'd0;
            cpu_err <= 1'b0;
            ldr_err <= 1'b0;
        end else begin
            wd_cnt  <= (state == WAIT) ? wd_cnt + 8'd1 : 8'd0;
            cpu_err <= timed_out && !owner;
            ldr_err <= timed_out && owner;
        end
    end
`else
    assign timed_out = 1'b0;
    assign cpu_err   = 1'b0;
    assign ldr_err   = 1'b0;
`endif

    // Command latch, controller drive and per-port response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr             <= 1'b0;
            owner              <= 1'b0;
            hold_cnt           <= 3'd0;
            mc_request         <= 1'b0;
            mc_request_type    <= 1'b0;
            mc_request_address <= 16'h0000;
            mc_memory_write    <= 16'h0000;
            cpu_rdata          <= 16'h0000;
            ldr_rdata          <= 16'h0000;
            cpu_done           <= 1'b0;
            ldr_done           <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            ldr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner              <= grant_sel;
                        rr_ptr             <= ~grant_sel;
                        hold_cnt           <= 3'd1;
                        mc_request         <= 1'b1;
                        mc_request_type    <= grant_sel ? ldr_we    : cpu_we;
                        mc_request_address <= grant_sel ? ldr_addr  : cpu_addr;
                        mc_memory_write    <= grant_sel ? ldr_wdata : cpu_wdata;
                    end
                end
                ISSUE: begin
                    if (hold_last)
                        mc_request <= 1'b0;
                    else
                        hold_cnt <= hold_cnt + 3'd1;
                end
                WAIT: begin
                    if (finish) begin
                        if (owner) begin
                            ldr_done <= 1'b1;
                            if (timed_out)
                                ldr_rdata <= 16'hDEAD;
                            else if (!mc_request_type)
                                ldr_rdata <= mc_data_out;
                        end else begin
                            cpu_done <= 1'b1;
                            if (timed_out)
                                cpu_rdata <= 16'hDEAD;
                            else if (!mc_request_type)
                                cpu_rdata <= mc_data_out;
                        end
                    end
                end
                RESP: begin
                    mc_request_type    <= 1'b0;
                    mc_request_address <= 16'h0000;
                    mc_memory_write    <= 16'h0000;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Scoreboard bench for memory_request_arbiter: directed transactions against a small controller model,
// plus a fixed-priority instance for the grant-order case.
module tb_memory_request_arbiter;

    localparam int REQ_HOLD   = 2;
    localparam int TB_TIMEOUT = 20;

    typedef struct {
        logic        port;
        logic        err;
        logic [15:0] cpu_rd;
        logic [15:0] ldr_rd;
        int          done_cycle;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [15:0] cpu_rdata, ldr_rdata;
    logic        cpu_done, cpu_err, ldr_done, ldr_err;
    logic        mc_request, mc_request_type;
    logic [15:0] mc_request_address, mc_memory_write;
    logic [15:0] mc_data_out;
    logic        mc_memory_ready, mc_write_complete;

    logic        fp_cpu_req, fp_ldr_req;
    logic [15:0] fp_cpu_rdata, fp_ldr_rdata;
    logic        fp_cpu_done, fp_cpu_err, fp_ldr_done, fp_ldr_err;
    logic        fp_mc_request, fp_mc_request_type;
    logic [15:0] fp_mc_request_address, fp_mc_memory_write;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle_count = 0;
    exp_t        sb[$];
    logic [15:0] m_cpu_rdata = 16'h0000;
    logic [15:0] m_ldr_rdata = 16'h0000;

    int          ctrl_delay = 0;
    bit          ctrl_wrong = 0;
    bit          ctrl_silent = 0;
    bit          ctrl_check = 0;
    logic [15:0] ctrl_data = 16'h0000;
    int          ctrl_req_cnt = 0;
    int          ctrl_bad = 0;
    logic        ctrl_exp_we = 1'b0;
    logic [15:0] ctrl_exp_addr = 16'h0000;
    logic [15:0] ctrl_exp_wdata = 16'h0000;

    memory_request_arbiter #(.PRIO_MODE(0), .REQ_HOLD(REQ_HOLD), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_done(ldr_done), .ldr_err(ldr_err),
        .mc_request(mc_request), .mc_request_type(mc_request_type),
        .mc_request_address(mc_request_address), .mc_memory_write(mc_memory_write),
        .mc_data_out(mc_data_out), .mc_memory_ready(mc_memory_ready),
        .mc_write_complete(mc_write_complete)
    );

    memory_request_arbiter #(.PRIO_MODE(1), .REQ_HOLD(REQ_HOLD), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut_fp (
        .clk(clk), .reset(reset),
        .cpu_req(fp_cpu_req), .cpu_we(1'b0), .cpu_addr(16'h0C0C), .cpu_wdata(16'h0000),
        .cpu_rdata(fp_cpu_rdata), .cpu_done(fp_cpu_done), .cpu_err(fp_cpu_err),
        .ldr_req(fp_ldr_req), .ldr_we(1'b0), .ldr_addr(16'h0D0D), .ldr_wdata(16'h0000),
        .ldr_rdata(fp_ldr_rdata), .ldr_done(fp_ldr_done), .ldr_err(fp_ldr_err),
        .mc_request(fp_mc_request), .mc_request_type(fp_mc_request_type),
        .mc_request_address(fp_mc_request_address), .mc_memory_write(fp_mc_memory_write),
        .mc_data_out(16'h7777), .mc_memory_ready(1'b1), .mc_write_complete(1'b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_count <= cycle_count + 1;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mc_request"}, mc_request, 0);
        checkOutput({tag, "_mc_request_type"}, mc_request_type, 0);
        checkOutput({tag, "_mc_request_address"}, mc_request_address, 0);
        checkOutput({tag, "_mc_memory_write"}, mc_memory_write, 0);
        checkOutput({tag, "_cpu_done"}, cpu_done, 0);
        checkOutput({tag, "_ldr_done"}, ldr_done, 0);
        checkOutput({tag, "_cpu_err"}, cpu_err, 0);
        checkOutput({tag, "_ldr_err"}, ldr_err, 0);
        checkOutput({tag, "_cpu_rdata"}, cpu_rdata, 0);
        checkOutput({tag, "_ldr_rdata"}, ldr_rdata, 0);
    endtask

    task automatic checkStable();
        if (ctrl_check && (mc_request_type !== ctrl_exp_we ||
                           mc_request_address !== ctrl_exp_addr ||
                           mc_memory_write !== ctrl_exp_wdata))
            ctrl_bad++;
    endtask

    // Controller model: after mc_request falls, answers on WAIT cycle ctrl_delay with the matching pulse
    initial begin : controller
        bit in_issue;
        bit is_read;
        in_issue          = 0;
        mc_memory_ready   = 1'b0;
        mc_write_complete = 1'b0;
        mc_data_out       = 16'h5A5A;
        forever begin
            @(negedge clk);
            if (mc_request === 1'b1) begin
                in_issue = 1;
                ctrl_req_cnt++;
                checkStable();
            end else if (in_issue) begin
                in_issue = 0;
                is_read  = !mc_request_type;
                if (!ctrl_silent) begin
                    for (int i = 0; i < ctrl_delay; i++) begin
                        checkStable();
                        if (ctrl_wrong && i == 1) begin
                            if (is_read) mc_write_complete = 1'b1;
                            else         mc_memory_ready   = 1'b1;
                        end
                        @(negedge clk);
                        mc_write_complete = 1'b0;
                        mc_memory_ready   = 1'b0;
                    end
                    checkStable();
                    if (is_read) begin
                        mc_memory_ready = 1'b1;
                        mc_data_out     = ctrl_data;
                    end else begin
                        mc_write_complete = 1'b1;
                    end
                    @(negedge clk);
                    mc_memory_ready   = 1'b0;
                    mc_write_complete = 1'b0;
                    mc_data_out       = 16'h5A5A;
                end
            end
        end
    end

    // Monitor: every done pulse consumes one scoreboard entry
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (cpu_done === 1'b1 || ldr_done === 1'b1)) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", {cpu_done, ldr_done}, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("cpu_done", cpu_done, !e.port);
                    checkOutput("ldr_done", ldr_done, e.port);
                    checkOutput("cpu_err", cpu_err, e.err && !e.port);
                    checkOutput("ldr_err", ldr_err, e.err && e.port);
                    checkOutput("cpu_rdata", cpu_rdata, e.cpu_rd);
                    checkOutput("ldr_rdata", ldr_rdata, e.ldr_rd);
                    if (e.done_cycle >= 0)
                        checkOutput("done_latency", cycle_count, e.done_cycle);
                end
            end
        end
    end

    task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] data,
                                 input int delay, input bit wrong, input bit tmo);
        exp_t e;
        bit   got;
        @(negedge clk);
        ctrl_delay     = delay;
        ctrl_wrong     = wrong;
        ctrl_silent    = 0;
        ctrl_check     = !tmo;
        ctrl_data      = data;
        ctrl_req_cnt   = 0;
        ctrl_bad       = 0;
        ctrl_exp_we    = we;
        ctrl_exp_addr  = addr;
        ctrl_exp_wdata = wdata;
        if (tmo || !we) begin
            if (port) m_ldr_rdata = tmo ? 16'hDEAD : data;
            else      m_cpu_rdata = tmo ? 16'hDEAD : data;
        end
        e.port       = port;
        e.err        = tmo;
        e.cpu_rd     = m_cpu_rdata;
        e.ldr_rd     = m_ldr_rdata;
        e.done_cycle = cycle_count + REQ_HOLD + 2 + (tmo ? TB_TIMEOUT - 1 : delay);
        sb.push_back(e);
        if (port) begin
            ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        @(negedge clk);
        if (port) begin
            ldr_we = ~we; ldr_addr = ~addr; ldr_wdata = ~wdata;
        end else begin
            cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wdata;
        end
        got = 0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if ((port ? ldr_done : cpu_done) === 1'b1) got = 1;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        checkOutput("done_seen", got, 1);
        checkOutput("req_hold_cycles", ctrl_req_cnt, REQ_HOLD);
        if (!tmo)
            checkOutput("mc_fields_stable", ctrl_bad, 0);
    endtask

    // Both requesters held high; expected grants alternate starting with cpu
    task automatic runContended(input int n);
        exp_t e;
        int   seen;
        @(negedge clk);
        ctrl_delay  = 0;
        ctrl_wrong  = 0;
        ctrl_silent = 0;
        ctrl_check  = 0;
        ctrl_data   = 16'h3C3C;
        for (int i = 0; i < n; i++) begin
            e.port = 1'(i % 2);
            e.err  = 1'b0;
            if (e.port) m_ldr_rdata = 16'h3C3C;
            else        m_cpu_rdata = 16'h3C3C;
            e.cpu_rd     = m_cpu_rdata;
            e.ldr_rd     = m_ldr_rdata;
            e.done_cycle = -1;
            sb.push_back(e);
        end
        cpu_we = 1'b0; cpu_addr = 16'h0A0A; cpu_wdata = 16'h0000;
        ldr_we = 1'b0; ldr_addr = 16'h0B0B; ldr_wdata = 16'h0000;
        cpu_req = 1'b1;
        ldr_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 400 && seen < n; c++) begin
            @(negedge clk);
            if (cpu_done === 1'b1 || ldr_done === 1'b1) seen++;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        checkOutput("contended_done_count", seen, n);
    endtask

    initial begin : stimulus
        int seen;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 16'h0000;
        fp_cpu_req = 1'b0;
        fp_ldr_req = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;

        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hCAFE, 16'h0000, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 16'h0123, 16'h0000, 16'hBEEF, 10, 0, 0);
        applyStimulus(1'b1, 1'b1, 16'hFF40, 16'h00A5, 16'h0000, 3, 0, 0);
        runContended(4);

        @(negedge clk);
        fp_cpu_req = 1'b1;
        fp_ldr_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 400 && seen < 4; c++) begin
            @(negedge clk);
            if (fp_cpu_done === 1'b1 || fp_ldr_done === 1'b1) begin
                seen++;
                checkOutput("fp_grant_is_ldr", fp_ldr_done, 1);
                checkOutput("fp_cpu_not_granted", fp_cpu_done, 0);
            end
        end
        fp_cpu_req = 1'b0;
        fp_ldr_req = 1'b0;
        checkOutput("fp_done_count", seen, 4);
        checkOutput("fp_ldr_rdata", fp_ldr_rdata, 16'h7777);
        checkOutput("fp_cpu_rdata", fp_cpu_rdata, 16'h0000);
        checkOutput("fp_err", {fp_cpu_err, fp_ldr_err}, 0);

        applyStimulus(1'b1, 1'b0, 16'h0777, 16'h0000, 16'h1234, 6, 1, 0);

        @(negedge clk);
        ctrl_silent = 1;
        ctrl_check  = 0;
        cpu_we = 1'b1; cpu_addr = 16'h4444; cpu_wdata = 16'h0101;
        ldr_we = 1'b1; ldr_addr = 16'h5555; ldr_wdata = 16'h0202;
        cpu_req = 1'b1;
        ldr_req = 1'b1;
        repeat (REQ_HOLD + 2) @(negedge clk);
        checkOutput("pre_reset_type", mc_request_type, 1);
        checkOutput("pre_reset_addr", mc_request_address, 16'h4444);
        checkOutput("pre_reset_wdata", mc_memory_write, 16'h0101);
        reset   = 1'b1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        #1;
        checkIdleOutputs("async_reset");
        @(negedge clk);
        checkIdleOutputs("reset_held");
        m_cpu_rdata = 16'h0000;
        m_ldr_rdata = 16'h0000;
        reset       = 1'b0;
        ctrl_silent = 0;
        runContended(1);

`ifdef ARB_TIMEOUT_EN
        applyStimulus(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1111, 25, 0, 1);
        repeat (12) @(negedge clk);
        checkOutput("late_ready_ignored", cpu_rdata, 16'hDEAD);
`endif

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
